// File: rtl/unidad_control.sv
// unidad_control: run/halt sequencing and zero-latency opcode decode for the single-cycle datapath.
// Optional single-step debug build: define UC_STEP_EN.
// Ports: clk, reset (async active-low), opcode[5:0], z_alu, start, [dbg, step];
//        s_inc, s_inm, we3, op[2:0], en_pc, zflag, halted, running, retired[CNT_W-1:0].
module unidad_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z_alu,
  input  logic             start,
`ifdef UC_STEP_EN
  input  logic             step,
  input  logic             dbg,
`endif
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic [2:0]       op,
  output logic             en_pc,
  output logic             zflag,
  output logic             halted,
  output logic             running,
  output logic [CNT_W-1:0] retired
);
`ifdef UC_STEP_EN
  typedef enum logic [1:0] {IDLE, RUN, HALT, STEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`endif
  state_t st, nxt;
  logic exec, is_halt, is_imm;
`ifdef UC_STEP_EN
  // prev is the step edge detector; go marks the single cycle a rising edge grants
  logic prev, go;
  assign exec = st == RUN || (st == STEP && go);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev <= 1'b0;
      go   <= 1'b0;
    end else begin
      prev <= step;
      go   <= st == STEP && step && !prev;
    end
`else
  assign exec = st == RUN;
`endif
  assign is_halt = opcode == 6'b000111;
  assign is_imm  = opcode[5:2] == 4'b0000;
  assign halted  = st == HALT;
`ifdef UC_STEP_EN
  assign running = st == RUN || st == STEP;
`else
  assign running = st == RUN;
`endif
  always_comb begin
    en_pc = exec && !is_halt;
    we3   = exec && (opcode[5] || is_imm);
    s_inm = exec && is_imm;
    op    = exec && opcode[5] ? opcode[4:2] : 3'b000;
    s_inc = !exec                ? 1'b1 :
            opcode == 6'b000100  ? 1'b0 :
            opcode == 6'b000101  ? ~zflag :
            opcode == 6'b000110  ? zflag : 1'b1;
`ifdef UC_STEP_EN
    nxt   = st == IDLE              ? (start ? RUN : IDLE) :
            exec && is_halt         ? HALT :
            st == RUN && dbg        ? STEP :
            st == STEP && !dbg      ? RUN : st;
`else
    nxt   = st == IDLE      ? (start ? RUN : IDLE) :
            exec && is_halt ? HALT : st;
`endif
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st      <= IDLE;
      zflag   <= 1'b0;
      retired <= '0;
    end else begin
      st <= nxt;
      if (exec) retired <= retired + CNT_W'(1);
      if (exec && opcode[5]) zflag <= z_alu;
    end
endmodule

// File: doc/unidad_control.md
# unidad_control

Sequencing control unit for the single-cycle microcontroller datapath. Decodes the 6-bit instruction opcode, holds the architectural zero flag, and drives the datapath control lines: PC increment/jump select, immediate/ALU write-back select, register-file write enable and ALU operation. Adds a run/halt state machine and a PC load enable so execution can be started, stopped and counted. Sits beside the datapath; the integration adds `en_pc` as the PC register load enable.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction[15:10] from program memory.
- `z_alu`  in  1  raw zero output of the ALU for the current instruction.
- `start`  in  1  level; leaves IDLE.
- `step`  in  1  single-step request (only with `UC_STEP_EN`).
- `dbg`  in  1  debug mode select (only with `UC_STEP_EN`).
- `s_inc`  out  1  1 = PC+1, 0 = jump to instruction[9:0].
- `s_inm`  out  1  1 = write-back immediate instruction[11:4], 0 = ALU result.
- `we3`  out  1  register-file write enable.
- `op`  out  3  ALU operation.
- `en_pc`  out  1  PC load enable.
- `zflag`  out  1  registered zero flag.
- `halted`  out  1  high in HALT.
- `running`  out  1  high while in RUN or STEP.
- `retired`  out  CNT_W  count of executed instructions.

## Operation
- States: IDLE, RUN, HALT (plus STEP with `UC_STEP_EN`). Reset state IDLE.
- IDLE -> RUN when `start`=1. RUN -> HALT when executing HALT. HALT exits only by reset.
- "Execute" cycle: any cycle in RUN, or the qualified step cycle in STEP. Only execute cycles assert `en_pc`, `we3`, update `zflag` or increment `retired`.
- Decode (execute cycles):
  - `opcode[5]`=1: ALU op; `op`=`opcode[4:2]`, `we3`=1, `s_inm`=0, `s_inc`=1; `zflag` <= `z_alu` at clock edge.
  - `opcode[5:2]`=0000: load immediate; `s_inm`=1, `we3`=1, `s_inc`=1; `zflag` unchanged.
  - 000100 J: `s_inc`=0.
  - 000101 JZ: `s_inc` = ~`zflag`. 000110 JNZ: `s_inc` = `zflag`.
  - 000111 HALT: `en_pc`=0, `we3`=0; next state HALT; counts as retired.
  - All other opcodes: NOP, `s_inc`=1, `we3`=0.
- Non-execute cycles: `en_pc`=0, `we3`=0, `s_inc`=1, `s_inm`=0, `op`=000; flag and counter held.
- Conditional jumps test the registered `zflag` (result of the last ALU instruction), never `z_alu`.
- `retired` wraps from 2^CNT_W-1 to 0 silently.

## Timing
- Control outputs are combinational from state, `opcode` and `zflag`: valid in the same cycle as the opcode, zero-latency decode; one instruction per cycle in RUN.
- Reset values: state IDLE, `zflag`=0, `retired`=0, `halted`=0, `running`=0, `en_pc`=0, `we3`=0, `s_inc`=1, `s_inm`=0, `op`=000.
- Reset asserted mid-instruction: all registers clear immediately; any write in that cycle is suppressed because `we3` goes 0 asynchronously.
- `start` sampled at rising edge; first execute cycle is the cycle after the IDLE->RUN edge.
- ALU op then JZ on consecutive cycles: JZ sees the flag written by that ALU op.

## Configuration
- `UC_STEP_EN` defined: `dbg`/`step` ports exist. In RUN with `dbg`=1 -> STEP; STEP with `dbg`=0 -> RUN. In STEP, a 0->1 transition of `step` (edge detector register, reset 0) makes exactly the next cycle an execute cycle; held-high `step` executes one instruction only. HALT executed in STEP goes to HALT.
- Not defined: no `dbg`/`step` ports, no STEP state, no edge register.

## Test plan
- Reset low mid-RUN after 5 instructions -> outputs at reset values in same cycle, `retired`=0, IDLE; `start`=1 resumes execution.
- `start`=1, opcode 100011 (ALU op 000), `z_alu`=1 -> `we3`=1, `op`=000, `zflag`=1 next cycle, `retired`=1.
- `zflag`=1 then opcode 000101 -> `s_inc`=0; with `zflag`=0 -> `s_inc`=1; opcode 000110 inverse.
- Opcode 000011 (load immediate) -> `s_inm`=1, `we3`=1, `zflag` unchanged; opcode 001010 -> NOP, `we3`=0.
- Opcode 000111 in RUN -> `en_pc`=0, `halted`=1 next cycle, stays halted with `start`=1 for 20 cycles, `retired` frozen.
- With `UC_STEP_EN`: `dbg`=1, `step` held high 10 cycles -> `retired` increments by exactly 1; three separate pulses -> +3.
